decoder_scan: RTL and testbench

Registered, parametrised N-to-2^N one-hot decoder with enable. It is the sequential successor to the team's gate-level 1-to-2 decoder. It has two modes:
- Direct: decodes the `in` bus.
- Scan: walks the one-hot output across all 2^N lines automatically, holding each line for a programmable dwell time.

It drives display digit/column selects and peripheral chip-selects in the lab designs.

---
 rtl/decoder_scan_if.sv | 14 +
 rtl/decoder_scan.sv | 71 +++++++
 tb/tb_decoder_scan.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_if.sv
// rtl/decoder_scan_if.sv - control and output bundle of the registered one-hot decoder/scanner
interface decoder_scan_if #(
  parameter int N = 3
);
  logic              enable;
  logic              mode;
  logic [N-1:0]      in;
  logic [(1<<N)-1:0] out;
  logic [N-1:0]      sel;
  logic              wrap;

  modport master (output enable, mode, in, input out, sel, wrap);
  modport slave  (input enable, mode, in, output out, sel, wrap);
endinterface

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered N-to-2^N one-hot decoder with direct and auto-scan modes
module decoder_scan #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           reset,
  decoder_scan_if.slave  bus
);
  localparam int W  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [N-1:0]  r_sel, w_sel_nx;
  logic [W-1:0]  r_out, w_out_nx;
  logic          r_wrap, w_wrap_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Outputs are derived from the next state so that every output is registered on the same edge.
  always_comb begin
    w_state_nx = IDLE;
    w_sel_nx   = '0;
    w_cnt_nx   = '0;
    w_wrap_nx  = 1'b0;
    w_out_nx   = '0;
    if (bus.enable) w_state_nx = bus.mode ? SCAN : DIRECT;
    case (w_state_nx)
      DIRECT: w_sel_nx = bus.in;
      SCAN: begin
        // Entering SCAN leaves sel/cnt at zero: a sweep always restarts at index 0.
        if (r_state == SCAN) begin
          if (r_cnt == CNT_LAST) begin
            w_sel_nx  = r_sel + N'(1);
            w_wrap_nx = &r_sel;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
            w_sel_nx = r_sel;
          end
        end
      end
      default: ;
    endcase
    if (w_state_nx != IDLE) w_out_nx[w_sel_nx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sel  <= '0;
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nx;
      r_sel  <= w_sel_nx;
      r_out  <= w_out_nx;
      r_wrap <= w_wrap_nx;
    end
  end

  assign bus.out  = r_out;
  assign bus.sel  = r_sel;
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - scoreboard bench for decoder_scan (N=3/DWELL=4 and N=2/DWELL=1)
module tb_decoder_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, b_rst;
  decoder_scan_if #(.N(3)) a_if ();
  decoder_scan_if #(.N(2)) b_if ();

  decoder_scan #(.N(3), .DWELL(4)) u_a (.clk(clk), .reset(a_rst), .bus(a_if));
  decoder_scan #(.N(2), .DWELL(1)) u_b (.clk(clk), .reset(b_rst), .bus(b_if));

  typedef struct {
    int         due;
    logic [7:0] out;
    logic [2:0] sel;
    logic       wrap;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   a_k = 0;
  int   b_k = 0;
  logic [7:0] dtab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic inv_a;
    inv_a = (a_if.out == 8'h00) || (a_if.out == (8'h01 << a_if.sel));
    check("a_onehot", {31'b0, inv_a}, 32'd1);
    while (q_a.size() > 0 && q_a[0].due <= cyc) begin
      ea = q_a.pop_front();
      check("a_due", ea.due, cyc);
      check("a_out", a_if.out, ea.out);
      check("a_sel", a_if.sel, ea.sel);
      check("a_wrap", a_if.wrap, ea.wrap);
    end
  end

  always @(negedge clk) begin
    logic inv_b;
    inv_b = (b_if.out == 4'h0) || (b_if.out == (4'h1 << b_if.sel));
    check("b_onehot", {31'b0, inv_b}, 32'd1);
    while (q_b.size() > 0 && q_b[0].due <= cyc) begin
      eb = q_b.pop_front();
      check("b_due", eb.due, cyc);
      check("b_out", b_if.out, eb.out[3:0]);
      check("b_sel", b_if.sel, eb.sel[1:0]);
      check("b_wrap", b_if.wrap, eb.wrap);
    end
  end

  task automatic drive_a(input logic en, input logic md, input logic [2:0] iv,
                         input logic [7:0] eo, input logic [2:0] es, input logic ew);
    exp_t e;
    @(negedge clk);
    a_if.enable = en;
    a_if.mode   = md;
    a_if.in     = iv;
    e.due = cyc + 1; e.out = eo; e.sel = es; e.wrap = ew;
    q_a.push_back(e);
  endtask

  // Expected scan position is derived from cycles since entry: index k/DWELL, wrap every 32 cycles.
  task automatic scan_a(input int n, input bit restart);
    logic [7:0] one;
    int idx;
    one = 8'h01;
    if (restart) a_k = 0;
    for (int i = 0; i < n; i++) begin
      idx = (a_k / 4) % 8;
      drive_a(1'b1, 1'b1, 3'(7 - (i % 8)), one << idx, 3'(idx), (a_k % 32 == 0) && (a_k != 0));
      a_k++;
    end
  endtask

  task automatic scan_b(input int n);
    exp_t e;
    logic [7:0] one;
    one = 8'h01;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b_if.enable = 1'b1;
      b_if.mode   = 1'b1;
      b_if.in     = 2'(i);
      e.due = cyc + 1; e.out = one << (b_k % 4); e.sel = 3'(b_k % 4);
      e.wrap = (b_k % 4 == 0) && (b_k != 0);
      q_b.push_back(e);
      b_k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b0; b_rst = 1'b1;
    a_if.enable = 1'b0; a_if.mode = 1'b0; a_if.in = '0;
    b_if.enable = 1'b0; b_if.mode = 1'b0; b_if.in = '0;

    // asynchronous reset takes effect before any clock edge
    #2 a_rst = 1'b1;
    #1;
    check("rst_async_out", a_if.out, 32'h0);
    check("rst_async_sel", a_if.sel, 32'h0);
    check("rst_async_wrap", a_if.wrap, 32'h0);
    @(negedge clk);
    a_rst = 1'b0;

    repeat (5) drive_a(1'b0, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0);

    for (int i = 0; i < 8; i++) drive_a(1'b1, 1'b0, 3'(i), dtab[i], 3'(i), 1'b0);
    drive_a(1'b0, 1'b0, 3'd3, 8'h00, 3'd0, 1'b0);

    scan_a(40, 1'b1);

    // one idle cycle mid-scan, then the sweep restarts at 0
    drive_a(1'b0, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0);
    scan_a(21, 1'b1);
    drive_a(1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b0);
    scan_a(25, 1'b1);

    // reset mid-scan at sel=6, release while still requesting scan
    drive_a(1'b1, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0);
    #2 a_rst = 1'b1;
    #1;
    check("rst_scan_out", a_if.out, 32'h0);
    check("rst_scan_sel", a_if.sel, 32'h0);
    check("rst_scan_wrap", a_if.wrap, 32'h0);
    #4 a_rst = 1'b0;
    scan_a(9, 1'b1);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0);

    @(negedge clk);
    b_rst = 1'b0;
    scan_b(9);

    repeat (3) @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
